// File: rtl/gate_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gate_seq_pkg : shared state encoding and NOR reference function     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package gate_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int NUM_VECTORS = 4;

  function automatic logic nor_expect(input logic a, input logic b);
    return ~(a | b);
  endfunction

endpackage
`default_nettype wire

// File: rtl/settle_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | settle_timer : 4-bit loadable down-counter with zero flag           |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == 4'd0);

endmodule
`default_nettype wire

// File: rtl/gate_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gate_seq_ctrl : walks a 2-input NOR through all four input vectors  |
// |                 and records mismatches against the expected output  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module gate_seq_ctrl
  import gate_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             gate_y,
  output logic             gate_a,
  output logic             gate_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       fail_vec
);

  // Timer is loaded with N-1 so the zero flag marks the last SETTLE cycle.
  localparam logic [3:0]       SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};
  localparam logic [1:0]       LAST_IDX    = 2'(NUM_VECTORS - 1);

  state_t           state_q,    state_d;
  logic [1:0]       idx_q,      idx_d;
  logic [ERR_W-1:0] err_cnt_q,  err_cnt_d;
  logic [1:0]       fail_vec_q, fail_vec_d;
  logic             pass_q,     pass_d;

  logic timer_load;
  logic timer_dec;
  logic timer_zero;

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (SETTLE_LOAD),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  assign busy     = (state_q == ST_APPLY) || (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign gate_a   = busy & idx_q[1];
  assign gate_b   = busy & idx_q[0];
  assign done     = (state_q == ST_DONE);
  assign pass     = pass_q;
  assign err_cnt  = err_cnt_q;
  assign fail_vec = fail_vec_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    err_cnt_d  = err_cnt_q;
    fail_vec_d = fail_vec_q;
    pass_d     = pass_q;
    timer_load = 1'b0;
    timer_dec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_APPLY;
          idx_d      = 2'd0;
          err_cnt_d  = '0;
          fail_vec_d = 2'd0;
          pass_d     = 1'b0;
        end
      end

      ST_APPLY: begin
        timer_load = 1'b1;
        state_d    = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
      end

      ST_SETTLE: begin
        timer_dec = 1'b1;
        if (timer_zero) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        if (gate_y != nor_expect(gate_a, gate_b)) begin
          if (err_cnt_q != ERR_MAX) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
          fail_vec_d = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          // Verdict includes the mismatch (if any) of this final sample.
          pass_d  = (err_cnt_d == '0);
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = ST_APPLY;
        end
      end

      ST_DONE: begin
        idx_d   = 2'd0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      err_cnt_q  <= '0;
      fail_vec_q <= 2'd0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      err_cnt_q  <= err_cnt_d;
      fail_vec_q <= fail_vec_d;
      pass_q     <= pass_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gate_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_gate_seq_ctrl : directed self-checking bench for gate_seq_ctrl   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_gate_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic start0, start1, start2;
  int   mode0;  // 0: good NOR, 1: output stuck at 1

  logic       a0, b0, y0, busy0, done0, pass0;
  logic [2:0] err0;
  logic [1:0] fv0;
  logic       a1, b1, y1, busy1, done1, pass1;
  logic [2:0] err1;
  logic [1:0] fv1;
  logic       a2, b2, y2, busy2, done2, pass2;
  logic [0:0] err2;
  logic [1:0] fv2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign y0 = (mode0 == 1) ? 1'b1 : ~(a0 | b0);
  assign y1 = ~(a1 | b1);
  assign y2 = a2 | b2;

  gate_seq_ctrl #(.SETTLE_CYCLES(2), .ERR_W(3)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .gate_y(y0), .gate_a(a0), .gate_b(b0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_vec(fv0)
  );

  gate_seq_ctrl #(.SETTLE_CYCLES(0), .ERR_W(3)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .gate_y(y1), .gate_a(a1), .gate_b(b1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_vec(fv1)
  );

  gate_seq_ctrl #(.SETTLE_CYCLES(2), .ERR_W(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .gate_y(y2), .gate_a(a2), .gate_b(b2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .fail_vec(fv2)
  );

  task automatic test_reset();
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; mode0 = 0;
    #3;
    checks++;
    if ({a0, b0, busy0, done0, pass0, err0, fv0} !== 10'd0) begin
      failures++;
      $display("FAIL reset_dut0 got=%b want=0", {a0, b0, busy0, done0, pass0, err0, fv0});
    end
    checks++;
    if ({a1, b1, busy1, done1, pass1, err1, fv1, a2, b2, busy2, done2, pass2, err2, fv2} !== 18'd0) begin
      failures++;
      $display("FAIL reset_dut12 got=%b want=0",
               {a1, b1, busy1, done1, pass1, err1, fv1, a2, b2, busy2, done2, pass2, err2, fv2});
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_nor_pass();
    int cyc;
    bit vec_ok;
    mode0 = 0;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    cyc = 1; vec_ok = 1'b1;
    while (!done0 && cyc < 60) begin
      if (!busy0 || {a0, b0} !== 2'((cyc - 1) / 4)) vec_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 17) begin failures++; $display("FAIL nor_done_cycle got=%0d want=17", cyc); end
    checks++;
    if (!vec_ok) begin failures++; $display("FAIL nor_vector_order got=bad want=00,01,10,11 held 4 cycles each"); end
    checks++;
    if ({pass0, err0, fv0} !== 6'b1_000_00) begin
      failures++; $display("FAIL nor_result got pass=%b err=%0d fv=%b want pass=1 err=0 fv=00", pass0, err0, fv0);
    end
    checks++;
    if ({busy0, a0, b0} !== 3'b000) begin
      failures++; $display("FAIL nor_done_outputs got busy,a,b=%b want=000", {busy0, a0, b0});
    end
    @(posedge clk); #1;
    checks++;
    if ({done0, pass0} !== 2'b01) begin
      failures++; $display("FAIL nor_after_done got done,pass=%b want=01", {done0, pass0});
    end
  endtask

  task automatic test_stuck_high();
    int cyc;
    mode0 = 1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    checks++;
    if ({pass0, err0} !== 4'd0) begin
      failures++; $display("FAIL stuck_clear_on_start got pass,err=%b want=0000", {pass0, err0});
    end
    cyc = 1;
    while (!done0 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 17) begin failures++; $display("FAIL stuck_done_cycle got=%0d want=17", cyc); end
    checks++;
    if ({pass0, err0, fv0} !== 6'b0_011_11) begin
      failures++; $display("FAIL stuck_result got pass=%b err=%0d fv=%b want pass=0 err=3 fv=11", pass0, err0, fv0);
    end
    @(posedge clk); #1;
    mode0 = 0;
  endtask

  task automatic test_or_saturate();
    int cyc;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    cyc = 1;
    while (!done2 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 17) begin failures++; $display("FAIL or_done_cycle got=%0d want=17", cyc); end
    checks++;
    if ({pass2, err2, fv2} !== 4'b0_1_11) begin
      failures++; $display("FAIL or_saturate got pass=%b err=%0d fv=%b want pass=0 err=1 fv=11", pass2, err2, fv2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_settle_zero();
    int cyc;
    bit vec_ok;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    cyc = 1; vec_ok = 1'b1;
    while (!done1 && cyc < 60) begin
      if (!busy1 || {a1, b1} !== 2'((cyc - 1) / 2)) vec_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 9) begin failures++; $display("FAIL settle0_done_cycle got=%0d want=9", cyc); end
    checks++;
    if (!vec_ok) begin failures++; $display("FAIL settle0_vector_order got=bad want=each vector 2 cycles"); end
    checks++;
    if ({pass1, err1} !== 4'b1_000) begin
      failures++; $display("FAIL settle0_result got pass=%b err=%0d want pass=1 err=0", pass1, err1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    bit saw_done;
    mode0 = 1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
    end
    // Now in cycle 10: vector 2 is on the gate and vector 1 already mismatched.
    checks++;
    if ({busy0, a0, b0, err0, fv0} !== {3'b110, 3'd1, 2'b01}) begin
      failures++; $display("FAIL midrun_before_reset got busy=%b ab=%b err=%0d fv=%b want busy=1 ab=10 err=1 fv=01",
                           busy0, {a0, b0}, err0, fv0);
    end
    rst = 1'b1;
    #2;
    checks++;
    if ({a0, b0, busy0, done0, pass0, err0, fv0} !== 10'd0) begin
      failures++; $display("FAIL midrun_reset_outputs got=%b want=0", {a0, b0, busy0, done0, pass0, err0, fv0});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mode0 = 0;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done0 || busy0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin failures++; $display("FAIL midrun_no_done got=activity want=idle after abort"); end
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    cyc = 1;
    while (!done0 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 17 || pass0 !== 1'b1 || err0 !== 3'd0) begin
      failures++; $display("FAIL midrun_rerun got cyc=%0d pass=%b err=%0d want cyc=17 pass=1 err=0", cyc, pass0, err0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int ndone, first, second;
    mode0 = 0;
    ndone = 0; first = 0; second = 0;
    start0 = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done0) begin
        ndone++;
        if (ndone == 1) first = c;
        if (ndone == 2) second = c;
      end
    end
    start0 = 1'b0;
    checks++;
    if (ndone !== 2) begin failures++; $display("FAIL b2b_done_count got=%0d want=2", ndone); end
    checks++;
    if (first !== 17 || second !== 35) begin
      failures++; $display("FAIL b2b_done_cycles got=%0d,%0d want=17,35", first, second);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if ({busy0, done0, pass0} !== 3'b001) begin
      failures++; $display("FAIL b2b_final got busy,done,pass=%b want=001", {busy0, done0, pass0});
    end
  endtask

  initial begin
    test_reset();
    test_nor_pass();
    test_stuck_high();
    test_or_saturate();
    test_settle_zero();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
